// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension unit: 32-cycle shift-add multiply and
// 32-cycle restoring divide sharing one 64-bit accumulator.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an instruction, ready_o high
// MUL    | one shift-add step per cycle on the 64-bit accumulator
// DIV    | one restoring-division step per cycle (acc = {rem, quo})
// DONE   | sign correction applied, one-cycle writeback pulse
module muldiv_seq #(
  parameter int unsigned SUPPORT_MUL = 1,
  parameter int unsigned SUPPORT_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic [31:0] res_hold_q;
  logic [4:0]  rd_hold_q;

  logic        accept;
  logic        is_div;
  logic        sgn1;
  logic        sgn2;
  logic        neg1;
  logic        neg2;
  logic        div_zero;
  logic        div_ovf;
  logic        neg_res;
  logic [31:0] mag1;
  logic [31:0] mag2;

  logic [1:0]  ld_state;
  logic [63:0] ld_acc;
  logic        ld_neg;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;

  logic        hi_sel;
  logic [63:0] mul_fix;
  logic [31:0] div_sel;
  logic [31:0] done_res;

  // Handshake and status outputs
  assign ready_o = (state_q == S_IDLE);
  assign accept  = ready_o & valid_i & ~flush_i & rst_i;
  assign stall_o = ~ready_o | accept;
  assign valid_o = (state_q == S_DONE) & ~flush_i;
  assign result_o = (state_q == S_DONE) ? done_res : res_hold_q;
  assign rd_o     = (state_q == S_DONE) ? rd_q : rd_hold_q;

  // Operand signedness, magnitudes and divide corner cases at accept
  always_comb begin
    is_div   = op_i[2];
    sgn1     = 1'b0;
    sgn2     = 1'b0;
    if (is_div) begin
      sgn1 = ~op_i[0];
      sgn2 = ~op_i[0];
    end else begin
      sgn1 = (op_i[1:0] == 2'b01) | (op_i[1:0] == 2'b10);
      sgn2 = (op_i[1:0] == 2'b01);
    end
    neg1     = sgn1 & rs1_i[31];
    neg2     = sgn2 & rs2_i[31];
    mag1     = neg1 ? (32'd0 - rs1_i) : rs1_i;
    mag2     = neg2 ? (32'd0 - rs2_i) : rs2_i;
    div_zero = (rs2_i == 32'd0);
    div_ovf  = ~op_i[0] & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
    // remainder follows the dividend sign, everything else the XOR
    neg_res  = (is_div & op_i[1]) ? neg1 : (neg1 ^ neg2);
  end

  // Initial state and accumulator contents chosen at accept; corner cases
  // preload the raw answer and skip straight to DONE
  always_comb begin
    ld_state = S_DONE;
    ld_acc   = 64'd0;
    ld_neg   = 1'b0;
    if (!is_div) begin
      if (SUPPORT_MUL != 0) begin
        ld_state = S_MUL;
        ld_acc   = {32'd0, mag1};
        ld_neg   = neg_res;
      end
    end else if (SUPPORT_DIV != 0) begin
      if (div_zero) begin
        ld_acc = {rs1_i, 32'hFFFF_FFFF};
      end else if (div_ovf) begin
        ld_acc = {32'd0, 32'h8000_0000};
      end else begin
        ld_state = S_DIV;
        ld_acc   = {32'd0, mag1};
        ld_neg   = neg_res;
      end
    end
  end

  // One multiply step and one divide step, both computed from acc_q
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // when div_ge the difference is below the divisor, so 32 bits suffice
    div_rem   = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
    div_next  = {div_rem, acc_q[30:0], div_ge};
  end

  // Sign correction and result selection while in DONE
  always_comb begin
    hi_sel   = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);
    mul_fix  = neg_q ? (64'd0 - acc_q) : acc_q;
    div_sel  = hi_sel ? acc_q[63:32] : acc_q[31:0];
    done_res = 32'd0;
    if (op_q[2]) begin
      done_res = neg_q ? (32'd0 - div_sel) : div_sel;
    end else begin
      done_res = hi_sel ? mul_fix[63:32] : mul_fix[31:0];
    end
  end

  // Sequencer, iteration counter and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      opb_q   <= 32'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      neg_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= ld_state;
            cnt_q   <= 5'd0;
            acc_q   <= ld_acc;
            opb_q   <= mag2;
            op_q    <= op_i;
            rd_q    <= rd_i;
            neg_q   <= ld_neg;
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_DONE;
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Keep the last written-back result and index visible between pulses
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      res_hold_q <= 32'd0;
      rd_hold_q  <= 5'd0;
    end else if (valid_o) begin
      res_hold_q <= done_res;
      rd_hold_q  <= rd_q;
    end
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The module SHALL have parameter SUPPORT_MUL, default 1, which enables the MUL/MULH/MULHSU/MULHU sequencing.
REQ-002 The module SHALL have parameter SUPPORT_DIV, default 1, which enables the DIV/DIVU/REM/REMU sequencing.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port valid_i, input, 1 bit: a decoded M-extension instruction is presented.
REQ-006 The module SHALL have port op_i, input, 3 bits: the instruction func3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The module SHALL have ports rs1_i and rs2_i, input, 32 bits each: the operand values.
REQ-008 The module SHALL have port rd_i, input, 5 bits: the destination register index.
REQ-009 The module SHALL have port flush_i, input, 1 bit: abort any operation (trap or redirect).
REQ-010 The module SHALL have port ready_o, output, 1 bit: the block is idle and can accept.
REQ-011 The module SHALL have port stall_o, output, 1 bit: the pipeline must hold.
REQ-012 The module SHALL have port valid_o, output, 1 bit: a one-cycle result-writeback pulse.
REQ-013 The module SHALL have port result_o, output, 32 bits: the writeback data.
REQ-014 The module SHALL have port rd_o, output, 5 bits: the writeback register index.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-016 ready_o SHALL be high only in IDLE.
REQ-017 stall_o SHALL be high in MUL, DIV and DONE, and in the IDLE cycle in which valid_i is accepted.
REQ-018 The block SHALL accept only when valid_i=1, ready_o=1 and flush_i=0, latching op_i, rs1_i, rs2_i and rd_i at that edge; valid_i is ignored in all other cases.
REQ-019 On a multiply accept, the block SHALL latch operand magnitudes: rs1 is signed for MULH/MULHSU, rs2 is signed for MULH only, and MUL and MULHU are unsigned.
REQ-020 On a multiply accept, the result sign SHALL be the XOR of the effective operand signs.
REQ-021 The block SHALL then enter MUL and perform exactly 32 shift-add iterations on a 64-bit accumulator, one per cycle.
REQ-022 On a divide accept, the block SHALL use magnitudes for DIV/REM, with quotient sign = XOR of the operand signs and remainder sign = dividend sign.
REQ-023 On a divide accept, the block SHALL enter DIV and perform exactly 32 restoring-division iterations, one per cycle.
REQ-024 The iteration counter SHALL be 5 bits, wrap from 31 to 0, and cause the transition to DONE on the 32nd iteration.
REQ-025 In DONE, the block SHALL apply sign correction (two's-complement negate of the 64-bit product, quotient or remainder) and assert valid_o for exactly one cycle; the next state is IDLE.
REQ-026 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-027 Multiply latency SHALL be: valid_o high exactly 33 cycles after the accept edge.
REQ-028 Divide-by-zero (rs2=0) SHALL be detected at accept and go directly to DONE (valid_o 1 cycle after accept), with quotient 0xFFFFFFFF and remainder equal to rs1, for both signed and unsigned ops.
REQ-029 Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF) SHALL be detected at accept and go directly to DONE, with quotient 0x80000000 and remainder 0.
REQ-030 Normal divide latency SHALL be 33 cycles, as for multiply.
REQ-031 A disabled op class (SUPPORT_MUL=0 or SUPPORT_DIV=0) SHALL still be accepted, go directly to DONE, and return result_o=0.
REQ-032 flush_i=1 in any state SHALL force IDLE at the next edge with no valid_o; flush_i has priority over the DONE pulse (valid_o is gated low in the flush cycle).
REQ-033 result_o and rd_o SHALL hold their last values outside the valid_o cycle; consumers sample them only when valid_o=1.

Reset
REQ-034 When rst_i=0 at an edge, the FSM SHALL go to IDLE, the counter to 0, and valid_o=0, result_o=0, rd_o=0, stall_o=0, ready_o=1 from the next cycle, aborting any operation in progress.

Verification
REQ-035 The bench SHALL drive MUL 7 x 0xFFFFFFFD and check ready_o=0 during the operation and result_o=0xFFFFFFEB with valid_o exactly 33 cycles after accept.
REQ-036 The bench SHALL drive MULHU 0xFFFFFFFF x 0xFFFFFFFF and check result 0xFFFFFFFE, then MULH with the same operands and check 0x00000000, then MULHSU 0xFFFFFFFF x 2 and check 0xFFFFFFFF.
REQ-037 The bench SHALL drive DIV 0xFFFFFFF9 / 2 and check 0xFFFFFFFD, then REM with the same operands and check 0xFFFFFFFF, then DIVU 100/7 and check 14, then REMU 100/7 and check 2.
REQ-038 The bench SHALL drive DIVU 5/0 and check 0xFFFFFFFF, REM 5/0 and check 5, and DIV 0x80000000 / 0xFFFFFFFF and check 0x80000000, each with valid_o 1 cycle after accept.
REQ-039 The bench SHALL pulse flush_i at iteration 10 of a DIV and check no valid_o, ready_o=1 next cycle, and that a new MUL is then accepted and correct.
REQ-040 The bench SHALL drop rst_i low mid-MUL and check IDLE with all outputs at reset values, then check that valid_i asserted together with flush_i=1 is not accepted.
